// File: rtl/bus_pkg.sv
// Shared definitions for the valid/ready register bus: responder state
// encoding, default bus widths and the error-flag encoding.
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } slave_state_t;

   localparam int BUS_ADDR_W = 16;
   localparam int BUS_DATA_W = 32;

   localparam logic ERR_OK   = 1'b0;
   localparam logic ERR_FAIL = 1'b1;

endpackage

// File: rtl/slave_reg_bank.sv
// Register array for slave_reg: synchronous write port, registered read
// port that returns zero whenever no read is requested.
module slave_reg_bank #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 8,
   parameter int IDX_W    = $clog2(NUM_REGS)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_widx,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [IDX_W-1:0]  i_ridx,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [NUM_REGS];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_mem[i] <= '0;
         end
         r_rdata <= '0;
      end else begin
         if (i_we) begin
            r_mem[i_widx] <= i_wdata;
         end
         // Idle cycles clear the output so read_data is zero outside RESP
         r_rdata <= i_re ? r_mem[i_ridx] : '0;
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/slave_reg.sv
// Register-bank responder on the valid/ready bus: decodes a NUM_REGS word
// window at BASE_ADDR, inserts WAIT_STATES wait cycles, answers with a one-cycle ready.
module slave_reg
   import bus_pkg::*;
#(
   parameter int                ADDR_W      = BUS_ADDR_W,
   parameter int                DATA_W      = BUS_DATA_W,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(16'h0010),
   parameter int                NUM_REGS    = 8,
   parameter int                WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid,
   input  logic              read,
   input  logic              write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] read_data,
   output logic              ready,
   output logic              err
);

   localparam int              IDX_W    = $clog2(NUM_REGS);
   localparam logic [3:0]      CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
   localparam logic [ADDR_W:0] LIMIT    = {1'b0, BASE_ADDR} + (ADDR_W + 1)'(NUM_REGS);

   if (NUM_REGS < 2 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_chk_num_regs
      $error("slave_reg: NUM_REGS must be a power of two and at least 2");
   end
   if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_chk_wait_states
      $error("slave_reg: WAIT_STATES must be in 0..15");
   end
   if ((longint'(BASE_ADDR) + longint'(NUM_REGS)) > (longint'(1) << ADDR_W)) begin : g_chk_window
      $error("slave_reg: register window exceeds the address space");
   end

   slave_state_t      r_state;
   slave_state_t      w_next;
   logic [3:0]        r_cnt;
   logic              r_hold_rd;
   logic              r_hold_wr;
   logic [ADDR_W-1:0] r_hold_addr;
   logic [DATA_W-1:0] r_hold_wdata;
   logic              r_ready;
   logic              r_err;

   logic              w_idle;
   logic              w_req_rd;
   logic              w_req_wr;
   logic [ADDR_W-1:0] w_req_addr;
   logic [DATA_W-1:0] w_req_wdata;
   logic              w_hit;
   logic [IDX_W-1:0]  w_idx;
   logic              w_wr_ok;
   logic              w_rd_ok;
   logic              w_commit;

   // With no wait states the request goes straight to RESP, so decode must
   // see the live bus in IDLE and the held copy afterwards.
   assign w_idle      = (r_state == IDLE);
   assign w_req_rd    = w_idle ? read       : r_hold_rd;
   assign w_req_wr    = w_idle ? write      : r_hold_wr;
   assign w_req_addr  = w_idle ? addr       : r_hold_addr;
   assign w_req_wdata = w_idle ? write_data : r_hold_wdata;

   assign w_hit   = ({1'b0, w_req_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, w_req_addr} < LIMIT);
   assign w_idx   = IDX_W'(w_req_addr - BASE_ADDR);
   assign w_wr_ok = w_hit & w_req_wr & ~w_req_rd;
   assign w_rd_ok = w_hit & w_req_rd & ~w_req_wr;

   always_comb begin
      w_next   = r_state;
      w_commit = 1'b0;
      case (r_state)
         IDLE: begin
            if (valid) begin
               if (WAIT_STATES > 0) begin
                  w_next = WAIT;
               end else begin
                  w_next   = RESP;
                  w_commit = 1'b1;
               end
            end
         end
         WAIT: begin
            if (r_cnt == 4'd0) begin
               w_next   = RESP;
               w_commit = 1'b1;
            end
         end
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= 4'd0;
      end else if (w_idle && valid) begin
         r_cnt <= CNT_LOAD;
      end else if (r_state == WAIT && r_cnt != 4'd0) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_idle && valid) begin
         r_hold_rd    <= read;
         r_hold_wr    <= write;
         r_hold_addr  <= addr;
         r_hold_wdata <= write_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ready <= 1'b0;
         r_err   <= ERR_OK;
      end else begin
         r_ready <= w_commit;
         r_err   <= (w_commit && !(w_wr_ok || w_rd_ok)) ? ERR_FAIL : ERR_OK;
      end
   end

   slave_reg_bank #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
   ) u_bank (
      .i_clk   (clk),
      .i_rst   (reset),
      .i_we    (w_commit & w_wr_ok),
      .i_widx  (w_idx),
      .i_wdata (w_req_wdata),
      .i_re    (w_commit & w_rd_ok),
      .i_ridx  (w_idx),
      .o_rdata (read_data)
   );

   assign ready = r_ready;
   assign err   = r_err;

endmodule

// File: tb/tb_slave_reg.sv
// Bench for slave_reg: two instances (one and zero wait states) checked every
// cycle against a transaction-level model, plus directed literal checks.
module tb_slave_reg;

   localparam int          AW   = 16;
   localparam int          DW   = 32;
   localparam int          NR   = 8;
   localparam logic [15:0] BASE = 16'h0010;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]          valid = '0;
   logic [1:0]          rd    = '0;
   logic [1:0]          wr    = '0;
   logic [1:0][AW-1:0]  addr  = '0;
   logic [1:0][DW-1:0]  wdata = '0;
   logic [1:0][DW-1:0]  rdata;
   logic [1:0]          ready;
   logic [1:0]          err;

   slave_reg #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(BASE), .NUM_REGS(NR), .WAIT_STATES(1)) dut_ws1 (
      .clk(clk), .reset(reset), .valid(valid[0]), .read(rd[0]), .write(wr[0]),
      .addr(addr[0]), .write_data(wdata[0]), .read_data(rdata[0]), .ready(ready[0]), .err(err[0]));

   slave_reg #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(BASE), .NUM_REGS(NR), .WAIT_STATES(0)) dut_ws0 (
      .clk(clk), .reset(reset), .valid(valid[1]), .read(rd[1]), .write(wr[1]),
      .addr(addr[1]), .write_data(wdata[1]), .read_data(rdata[1]), .ready(ready[1]), .err(err[1]));

   int passed = 0;
   int total  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic int ws_of(input int d);
      return (d == 0) ? 1 : 0;
   endfunction

   // Transaction-level model: a request accepted at edge n completes at edge
   // n+WS; the next request can be accepted two edges after completion.
   logic [DW-1:0] m_regs [2][NR];
   bit            m_on = 1'b0;
   bit            m_pend [2];
   longint        m_n = 0;
   longint        m_resp [2];
   longint        m_next [2];
   logic          m_hr [2];
   logic          m_hw [2];
   logic [AW-1:0] m_ha [2];
   logic [DW-1:0] m_hd [2];
   int            m_off;
   bit            m_hit;
   logic [1:0]          e_ready = '0;
   logic [1:0]          e_err   = '0;
   logic [1:0][DW-1:0]  e_rd    = '0;

   always @(posedge clk) begin
      m_n++;
      if (reset) begin
         m_on = 1'b1;
         for (int d = 0; d < 2; d++) begin
            m_pend[d] = 1'b0;
            m_next[d] = m_n + 1;
            e_ready[d] = 1'b0;
            e_err[d]   = 1'b0;
            e_rd[d]    = '0;
            for (int i = 0; i < NR; i++) m_regs[d][i] = '0;
         end
      end else if (m_on) begin
         for (int d = 0; d < 2; d++) begin
            e_ready[d] = 1'b0;
            e_err[d]   = 1'b0;
            e_rd[d]    = '0;
            if (!m_pend[d] && m_n >= m_next[d] && valid[d]) begin
               m_pend[d] = 1'b1;
               m_hr[d] = rd[d];
               m_hw[d] = wr[d];
               m_ha[d] = addr[d];
               m_hd[d] = wdata[d];
               m_resp[d] = m_n + ws_of(d);
            end
            if (m_pend[d] && m_n == m_resp[d]) begin
               m_off = int'(m_ha[d]) - int'(BASE);
               m_hit = (m_off >= 0) && (m_off < NR);
               e_ready[d] = 1'b1;
               if (m_hit && m_hw[d] && !m_hr[d]) m_regs[d][m_off] = m_hd[d];
               else if (m_hit && m_hr[d] && !m_hw[d]) e_rd[d] = m_regs[d][m_off];
               else e_err[d] = 1'b1;
               m_pend[d] = 1'b0;
               m_next[d] = m_n + 2;
            end
         end
      end
   end

   logic [1:0] prev_ready = '0;
   always @(negedge clk) begin
      if (m_on) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("ready[%0d]", d), 64'(ready[d]), 64'(e_ready[d]));
            chk($sformatf("err[%0d]", d), 64'(err[d]), 64'(e_err[d]));
            chk($sformatf("read_data[%0d]", d), 64'(rdata[d]), 64'(e_rd[d]));
            chk($sformatf("ready_consecutive[%0d]", d), 64'(ready[d] & prev_ready[d]), 64'd0);
         end
         prev_ready = ready;
      end
   end

   task automatic txn(input int d, input bit r, input bit w, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input bit drop,
                      output int lat, output logic e, output logic [DW-1:0] rdv);
      bit got;
      @(negedge clk);
      valid[d] = 1'b1; rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = wd;
      lat = 0; e = 1'b0; rdv = '0; got = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         lat++;
         if (ready[d]) begin
            e = err[d]; rdv = rdata[d]; got = 1'b1;
            break;
         end
         if (drop && lat == 1) begin
            valid[d] = 1'b0; rd[d] = 1'($urandom); wr[d] = 1'($urandom); addr[d] = AW'($urandom);
         end
      end
      if (!got) begin
         chk($sformatf("timeout[%0d]", d), 64'd0, 64'd1);
         lat = -1;
      end
      valid[d] = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0;
      @(posedge clk); #1;
   endtask

   int            lat;
   logic          e;
   logic [DW-1:0] rdv;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_ready", 64'(ready), 64'd0);
      chk("reset_err", 64'(err), 64'd0);
      chk("reset_rdata0", 64'(rdata[0]), 64'd0);
      reset = 1'b0;

      txn(0, 1, 0, 16'h0010, '0, 0, lat, e, rdv);
      chk("rd_after_reset_data", 64'(rdv), 64'h0);
      chk("rd_after_reset_err", 64'(e), 64'd0);

      txn(0, 0, 1, 16'h0010, 32'hDEADBEEF, 0, lat, e, rdv);
      chk("wr_latency_ws1", 64'(lat), 64'd2);
      chk("wr_err", 64'(e), 64'd0);
      txn(0, 1, 0, 16'h0010, '0, 0, lat, e, rdv);
      chk("rd_deadbeef", 64'(rdv), 64'hDEADBEEF);
      chk("rd_latency_ws1", 64'(lat), 64'd2);

      txn(0, 1, 0, 16'h0018, '0, 0, lat, e, rdv);
      chk("miss_hi_err", 64'(e), 64'd1);
      chk("miss_hi_data", 64'(rdv), 64'd0);
      txn(0, 1, 0, 16'h000F, '0, 0, lat, e, rdv);
      chk("miss_lo_err", 64'(e), 64'd1);
      chk("miss_lo_data", 64'(rdv), 64'd0);
      txn(0, 0, 1, 16'h0018, 32'h12345678, 0, lat, e, rdv);
      chk("miss_wr_err", 64'(e), 64'd1);
      for (int i = 0; i < NR; i++) begin
         txn(0, 1, 0, BASE + 16'(i), '0, 0, lat, e, rdv);
         chk($sformatf("bank_after_miss[%0d]", i), 64'(rdv), (i == 0) ? 64'hDEADBEEF : 64'h0);
      end

      txn(0, 1, 1, 16'h0011, 32'h11111111, 0, lat, e, rdv);
      chk("rw_both_err", 64'(e), 64'd1);
      txn(0, 1, 0, 16'h0011, '0, 0, lat, e, rdv);
      chk("rw_both_reg1", 64'(rdv), 64'h0);
      txn(0, 0, 0, 16'h0011, 32'h22222222, 0, lat, e, rdv);
      chk("neither_err", 64'(e), 64'd1);

      // Abort an in-flight write with reset while it sits in WAIT
      @(negedge clk);
      valid[0] = 1'b1; wr[0] = 1'b1; rd[0] = 1'b0; addr[0] = 16'h0012; wdata[0] = 32'hCAFEF00D;
      @(posedge clk); #1;
      chk("abort_wait_ready", 64'(ready[0]), 64'd0);
      @(negedge clk);
      reset = 1'b1; valid[0] = 1'b0; wr[0] = 1'b0;
      @(posedge clk); #1;
      chk("abort_reset_ready", 64'(ready[0]), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      txn(0, 1, 0, 16'h0012, '0, 0, lat, e, rdv);
      chk("abort_reg2", 64'(rdv), 64'h0);
      txn(0, 1, 0, 16'h0010, '0, 0, lat, e, rdv);
      chk("abort_reg0_cleared", 64'(rdv), 64'h0);

      txn(1, 0, 1, 16'h0017, 32'hA5A5A5A5, 0, lat, e, rdv);
      chk("ws0_wr_latency", 64'(lat), 64'd1);
      chk("ws0_wr_err", 64'(e), 64'd0);
      txn(1, 1, 0, 16'h0017, '0, 0, lat, e, rdv);
      chk("ws0_rd_latency", 64'(lat), 64'd1);
      chk("ws0_rd_data", 64'(rdv), 64'hA5A5A5A5);

      for (int t = 0; t < 300; t++) begin
         int  d;
         int  kind;
         bit  r, w, drop;
         d    = int'($urandom_range(0, 1));
         kind = int'($urandom_range(0, 9));
         r    = (kind < 4) || (kind == 8);
         w    = ((kind >= 4) && (kind < 8)) || (kind == 8);
         drop = (d == 0) && ($urandom_range(0, 7) == 0);
         txn(d, r, w, AW'($urandom_range(16'h000C, 16'h001B)), $urandom, drop, lat, e, rdv);
         chk($sformatf("rand_latency[%0d]", d), 64'(lat), 64'(ws_of(d) + 1));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
